// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - sequential load/store front-end between execute and data memory
//
// Purpose:
//   Latches the execute-stage address and store operand and runs one
//   valid/ready request to data memory. The pipeline stalls while the access
//   is outstanding. A one-cycle load_valid pulse (with err) reports the result.
//   A bounded wait counter aborts the access with err if memory never answers.
//
// Optional feature macro: DMEM_ALIGN_CHECK_EN
//   defined   : a legal start with addr[1:0] != 0 is rejected (err, no request)
//   undefined : no check; dmem_addr is silently word-aligned
//
// Parameters:
//   TIMEOUT      maximum REQ cycles before the access is aborted (1..255)
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   mem_read     load request from execute (level, sampled in IDLE)
//   mem_write    store request from execute (level, sampled in IDLE)
//   addr         byte address (ALU result)
//   wdata        store data (register-B operand)
//   dmem_valid   request valid to data memory
//   dmem_we      1 = write, 0 = read (only meaningful with dmem_valid)
//   dmem_addr    latched, word-aligned address
//   dmem_wdata   latched store data
//   dmem_ready   memory accepts/completes the request
//   dmem_rdata   read data, valid with dmem_ready
//   stall        freeze upstream stages (combinational)
//   load_data    captured read data, held until the next DONE
//   load_valid   one-cycle pulse: access finished
//   err          one-cycle pulse with load_valid: access failed

module dmem_access_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmem_valid,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic [7:0]  cnt_inc;
  logic [29:0] addr_q;      // only the word address is ever presented
  logic [31:0] wdata_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] load_data_q;

  logic start;
  logic illegal;
  logic misalign;

  assign start   = mem_read ^ mem_write;
  assign illegal = mem_read & mem_write;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = (addr[1:0] != 2'b00);
`else
  logic addr_lo_unused;
  assign misalign       = 1'b0;
  assign addr_lo_unused = ^addr[1:0];
`endif

  // Counter saturates rather than wrapping; with TIMEOUT <= 255 the abort
  // always fires before saturation, this only guards odd parameterisations.
  assign cnt_inc = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= 8'd0;
      addr_q      <= 30'd0;
      wdata_q     <= 32'd0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      load_data_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (illegal || (start && misalign)) begin
            // Rejected request: nothing is latched, report failure directly.
            err_q       <= 1'b1;
            load_data_q <= 32'd0;
            state       <= S_DONE;
          end else if (start) begin
            addr_q   <= addr[31:2];
            wdata_q  <= wdata;
            we_q     <= mem_write;
            wait_cnt <= 8'd0;
            state    <= S_REQ;
          end
        end

        S_REQ: begin
          if (dmem_ready) begin
            // A response in the final allowed cycle still wins over timeout.
            load_data_q <= we_q ? 32'd0 : dmem_rdata;
            err_q       <= 1'b0;
            state       <= S_DONE;
          end else begin
            wait_cnt <= cnt_inc;
            if (cnt_inc == TIMEOUT_C) begin
              load_data_q <= 32'd0;
              err_q       <= 1'b1;
              state       <= S_DONE;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign dmem_valid = (state == S_REQ);
  assign dmem_we    = (state == S_REQ) & we_q;
  assign dmem_addr  = {addr_q, 2'b00};
  assign dmem_wdata = wdata_q;
  assign stall      = ((state == S_IDLE) & (mem_read | mem_write)) | (state == S_REQ);
  assign load_data  = load_data_q;
  assign load_valid = (state == S_DONE);
  assign err        = (state == S_DONE) & err_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - self-checking bench for dmem_access_unit

module tb_dmem_access_unit;

  localparam int TO = 15;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic        dmem_valid, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what the access unit should be presenting/holding.
  logic [31:0] m_addr, m_wdata, m_ld;

  dmem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata),
    .dmem_valid(dmem_valid), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access. delay = number of not-ready REQ cycles before
  // dmem_ready (negative = never answers).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int delay, input logic [31:0] rdat);
    bit rejected;
    bit tmo;
    int nreq;
    rejected = (rd & wr) | (ALIGN & (a[1:0] != 2'b00));
    if (rejected) begin
      tmo  = 1'b1;
      nreq = 0;
      m_ld = 32'd0;
    end else begin
      m_addr  = {a[31:2], 2'b00};
      m_wdata = wd;
      tmo     = (delay < 0) || (delay >= TO);
      nreq    = tmo ? TO : delay + 1;
      m_ld    = (tmo || wr) ? 32'd0 : rdat;
    end

    // Issue cycle (IDLE)
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    dmem_ready = 1'b0; dmem_rdata = $urandom;
    #1;
    chk("issue_stall", {31'd0, stall}, {31'd0, rd | wr});
    chk("issue_valid", {31'd0, dmem_valid}, 32'd0);
    chk("issue_load_valid", {31'd0, load_valid}, 32'd0);
    step();

    // REQ cycles: upstream inputs scrambled to prove the latched values hold
    for (int i = 0; i < nreq; i++) begin
      mem_read = 1'($urandom); mem_write = 1'($urandom);
      addr = $urandom; wdata = $urandom;
      dmem_ready = (i == delay);
      dmem_rdata = (i == delay) ? rdat : $urandom;
      #1;
      chk("req_valid", {31'd0, dmem_valid}, 32'd1);
      chk("req_we", {31'd0, dmem_we}, {31'd0, wr});
      chk("req_addr", dmem_addr, m_addr);
      chk("req_wdata", dmem_wdata, m_wdata);
      chk("req_stall", {31'd0, stall}, 32'd1);
      chk("req_load_valid", {31'd0, load_valid}, 32'd0);
      step();
    end

    // DONE cycle: requests must be ignored here
    mem_read = 1'($urandom); mem_write = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    dmem_ready = 1'($urandom); dmem_rdata = $urandom;
    #1;
    chk("done_load_valid", {31'd0, load_valid}, 32'd1);
    chk("done_err", {31'd0, err}, {31'd0, tmo});
    chk("done_load_data", load_data, m_ld);
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_valid", {31'd0, dmem_valid}, 32'd0);
    chk("done_we", {31'd0, dmem_we}, 32'd0);
    chk("done_addr", dmem_addr, m_addr);
    step();

    // Back in IDLE
    mem_read = 1'b0; mem_write = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("idle_load_valid", {31'd0, load_valid}, 32'd0);
    chk("idle_err", {31'd0, err}, 32'd0);
    chk("idle_load_data", load_data, m_ld);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_wdata", dmem_wdata, m_wdata);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, dmem_valid}, 32'd0);
    chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_load_valid"}, {31'd0, load_valid}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    int op;
    int dly;
    logic [31:0] a;

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'd0; wdata = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    m_addr = 32'd0; m_wdata = 32'd0; m_ld = 32'd0;
    step(); step();
    rst = 1'b0;
    #1;
    chk_all_zero("reset");

    // Minimum-latency load
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF);
    // Store with ready delayed three cycles
    access(1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 3, 32'hFFFF_FFFF);
    // Load that never gets an answer
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, -1, 32'h0);
    // Answer in the last allowed REQ cycle beats the timeout
    access(1'b1, 1'b0, 32'h0000_0104, 32'h0, TO - 1, 32'hA5A5_0001);
    // Illegal: read and write together
    access(1'b1, 1'b1, 32'h0000_0200, 32'h5555_AAAA, 0, 32'h0);
    // Misaligned load
    access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'hCAFE_F00D);

    // Reset in the second REQ cycle drops the access
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h0000_0300; wdata = 32'h0;
    dmem_ready = 1'b0;
    step();
    #1;
    chk("rstreq_valid", {31'd0, dmem_valid}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    m_addr = 32'd0; m_wdata = 32'd0; m_ld = 32'd0;
    #1;
    chk_all_zero("midreset");
    access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1, 32'h0BAD_F00D);

    // Randomised accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      op  = $urandom_range(0, 9);
      a   = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      dly = $urandom_range(0, 6);
      if ($urandom_range(0, 7) == 0) dly = -1;
      if ($urandom_range(0, 9) == 0) dly = TO - 1;
      access(op == 0 ? 1'b1 : (op < 5), op == 0 ? 1'b1 : (op >= 5),
             a, $urandom, dly, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
